ysyx_23060208_sram_arbiter: RTL

Two-master read arbiter that shares the single instruction/data SRAM read port (AR/R channel pair, AXI-lite style) between the IFU and the LSU. It sits between the two requesters and the SRAM model and keeps exactly one read outstanding. Masters are granted round-robin. All payload is routed to and from the granted master only. LSU writes do not pass through this block.

---
 rtl/ysyx_23060208_arb_pkg.sv | 27 ++
 rtl/ysyx_23060208_rr_arb2.sv | 35 +++
 rtl/ysyx_23060208_sram_arbiter.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/ysyx_23060208_arb_pkg.sv
// ---------------------------------------------------------------------------
// ysyx_23060208_arb_pkg
// Shared types and constants for the IFU/LSU SRAM read arbiter.
//   arb_state_e : arbiter FSM states (3-bit encoding)
//   MST_IFU/LSU : master identifiers used by the grant logic
//   RESP_OKAY   : AXI OKAY response, also the idle value of rresp
// ---------------------------------------------------------------------------
package ysyx_23060208_arb_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    AR_IFU = 3'd1,
    R_IFU  = 3'd2,
    AR_LSU = 3'd3,
    R_LSU  = 3'd4
  } arb_state_e;

  localparam logic       MST_IFU   = 1'b0;
  localparam logic       MST_LSU   = 1'b1;
  localparam logic [1:0] RESP_OKAY = 2'b00;

  // Address-phase state that serves the given master.
  function automatic arb_state_e ar_state_of(input logic mst);
    return (mst == MST_IFU) ? AR_IFU : AR_LSU;
  endfunction

endpackage

// File: rtl/ysyx_23060208_rr_arb2.sv
// ---------------------------------------------------------------------------
// ysyx_23060208_rr_arb2
// Two-way round-robin picker. Purely combinational.
//   req[1:0]   : request vector, bit 0 = IFU, bit 1 = LSU
//   last_grant : master that won the previous contended round
//   enable     : picker is only meaningful while the arbiter is idle
//   grant      : id of the selected master
// When no request is present (or the picker is disabled) the output simply
// repeats last_grant; the caller ignores it in that case.
// ---------------------------------------------------------------------------
module ysyx_23060208_rr_arb2
  import ysyx_23060208_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  input  logic       enable,
  output logic       grant
);

  // Pick the lone requester, or the one that did not win last time.
  always_comb begin
    grant = last_grant;
    if (enable) begin
      case (req)
        2'b01:   grant = MST_IFU;
        2'b10:   grant = MST_LSU;
        2'b11:   grant = ~last_grant;
        default: grant = last_grant;
      endcase
    end else begin
      grant = last_grant;
    end
  end

endmodule

// File: rtl/ysyx_23060208_sram_arbiter.sv
// ---------------------------------------------------------------------------
// ysyx_23060208_sram_arbiter
// Shares the single SRAM read port (AR/R) between IFU and LSU, one read
// outstanding at a time, round-robin on contention.
//   clk, rst            : clock, asynchronous active-low reset
//   ifu_ar*/ifu_r*      : IFU read address / read data channels
//   lsu_ar*/lsu_r*      : LSU read address / read data channels
//   sram_ar*/sram_r*    : downstream SRAM read channels
// All outputs are decodes of the registered state plus the granted master's
// and SRAM's live inputs; the grant itself depends only on arvalid and
// last_grant, so no sram_* input reaches the arbitration decision.
// ---------------------------------------------------------------------------
module ysyx_23060208_sram_arbiter
  import ysyx_23060208_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] ifu_araddr,
  input  logic                  ifu_arvalid,
  output logic                  ifu_arready,
  output logic [DATA_WIDTH-1:0] ifu_rdata,
  output logic [1:0]            ifu_rresp,
  output logic                  ifu_rvalid,
  input  logic                  ifu_rready,
  input  logic [DATA_WIDTH-1:0] lsu_araddr,
  input  logic                  lsu_arvalid,
  output logic                  lsu_arready,
  output logic [DATA_WIDTH-1:0] lsu_rdata,
  output logic [1:0]            lsu_rresp,
  output logic                  lsu_rvalid,
  input  logic                  lsu_rready,
  output logic [DATA_WIDTH-1:0] sram_araddr,
  output logic                  sram_arvalid,
  input  logic                  sram_arready,
  input  logic [DATA_WIDTH-1:0] sram_rdata,
  input  logic [1:0]            sram_rresp,
  input  logic                  sram_rvalid,
  output logic                  sram_rready
);

  arb_state_e state_r;
  arb_state_e state_nxt_s;
  logic       last_grant_r;
  logic       grant_s;
  logic       idle_s;
  logic       contended_s;

  assign idle_s      = (state_r == IDLE);
  assign contended_s = idle_s && ifu_arvalid && lsu_arvalid;

  ysyx_23060208_rr_arb2 u_rr_arb2 (
    .req        ({lsu_arvalid, ifu_arvalid}),
    .last_grant (last_grant_r),
    .enable     (idle_s),
    .grant      (grant_s)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Round-robin history: only a contended round moves the pointer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant_r <= MST_LSU;
    end else if (contended_s) begin
      last_grant_r <= grant_s;
    end else begin
      last_grant_r <= last_grant_r;
    end
  end

  // Next-state logic; each phase ends on its own handshake.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (ifu_arvalid || lsu_arvalid) begin
          state_nxt_s = ar_state_of(grant_s);
        end else begin
          state_nxt_s = IDLE;
        end
      end
      AR_IFU: begin
        if (ifu_arvalid && sram_arready) begin
          state_nxt_s = R_IFU;
        end else begin
          state_nxt_s = AR_IFU;
        end
      end
      R_IFU: begin
        if (sram_rvalid && ifu_rready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = R_IFU;
        end
      end
      AR_LSU: begin
        if (lsu_arvalid && sram_arready) begin
          state_nxt_s = R_LSU;
        end else begin
          state_nxt_s = AR_LSU;
        end
      end
      R_LSU: begin
        if (sram_rvalid && lsu_rready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = R_LSU;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Channel muxes: only the granted master sees the SRAM, everyone else idles.
  always_comb begin
    ifu_arready  = 1'b0;
    ifu_rvalid   = 1'b0;
    ifu_rdata    = {DATA_WIDTH{1'b0}};
    ifu_rresp    = RESP_OKAY;
    lsu_arready  = 1'b0;
    lsu_rvalid   = 1'b0;
    lsu_rdata    = {DATA_WIDTH{1'b0}};
    lsu_rresp    = RESP_OKAY;
    sram_araddr  = {DATA_WIDTH{1'b0}};
    sram_arvalid = 1'b0;
    sram_rready  = 1'b0;
    case (state_r)
      AR_IFU: begin
        sram_araddr  = ifu_araddr;
        sram_arvalid = ifu_arvalid;
        ifu_arready  = sram_arready;
      end
      R_IFU: begin
        ifu_rvalid  = sram_rvalid;
        ifu_rdata   = sram_rdata;
        ifu_rresp   = sram_rresp;
        sram_rready = ifu_rready;
      end
      AR_LSU: begin
        sram_araddr  = lsu_araddr;
        sram_arvalid = lsu_arvalid;
        lsu_arready  = sram_arready;
      end
      R_LSU: begin
        lsu_rvalid  = sram_rvalid;
        lsu_rdata   = sram_rdata;
        lsu_rresp   = sram_rresp;
        sram_rready = lsu_rready;
      end
      default: begin
        sram_arvalid = 1'b0;
      end
    endcase
  end

endmodule
